// File: rtl/sm_7seg_scan_ctrl_if.sv
// Bus bundle for the 7-segment scan controller: control/pattern inputs and the multiplexed pin outputs.
interface sm_7seg_scan_ctrl_if #(
  parameter int unsigned DIGITS = 3
);
  logic                  enable;
  logic                  load;
  logic [7*DIGITS-1:0]   seg_in;
  logic [DIGITS-1:0]     dp_in;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     dig_sel;
  logic                  frame_done;

  modport master (
    output enable, load, seg_in, dp_in,
    input  seg, dp, dig_sel, frame_done
  );

  modport slave (
    input  enable, load, seg_in, dp_in,
    output seg, dp, dig_sel, frame_done
  );
endinterface

// File: rtl/sm_7seg_scan_ctrl.sv
// Multiplexed 7-segment scan scheduler: per-digit blank/show slots, double-buffered patterns
// swapped only at frame boundaries, all pin outputs registered.
module sm_7seg_scan_ctrl #(
  parameter int unsigned DIGITS       = 3,
  parameter int unsigned SHOW_CYCLES  = 25000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned SEG_ACT_LOW  = 1,
  parameter int unsigned SEL_ACT_LOW  = 1
) (
  input logic                clk,
  input logic                rst,
  sm_7seg_scan_ctrl_if.slave bus
);

  localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]  SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  localparam logic              SEG_LOW = (SEG_ACT_LOW != 0);
  localparam logic              SEL_LOW = (SEL_ACT_LOW != 0);
  localparam logic [6:0]        SEG_OFF = {7{SEG_LOW}};
  localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{SEL_LOW}};

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  typedef logic [DIGITS-1:0][6:0] seg_arr_t;

  logic [0:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  seg_arr_t          act_seg_q, act_seg_d;
  logic [DIGITS-1:0] act_dp_q, act_dp_d;
  seg_arr_t          pend_seg_q, pend_seg_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic              pend_vld_q, pend_vld_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic              frame_done_q, frame_done_d;

  logic              boundary_c;

  // The buffer swap happens while the frame_done pulse is on the pins and scanning is live.
  assign boundary_c = frame_done_q & bus.enable;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    act_seg_d    = act_seg_q;
    act_dp_d     = act_dp_q;
    pend_seg_d   = pend_seg_q;
    pend_dp_d    = pend_dp_q;
    pend_vld_d   = pend_vld_q;
    frame_done_d = 1'b0;
    seg_d        = seg_q;
    dp_d         = dp_q;
    dig_sel_d    = SEL_OFF;

    if (boundary_c) begin
      if (bus.load) begin
        act_seg_d = bus.seg_in;
        act_dp_d  = bus.dp_in;
      end else if (pend_vld_q) begin
        act_seg_d = pend_seg_q;
        act_dp_d  = pend_dp_q;
      end
      pend_vld_d = 1'b0;
    end else if (bus.load) begin
      pend_seg_d = bus.seg_in;
      pend_dp_d  = bus.dp_in;
      pend_vld_d = 1'b1;
    end

    if (!bus.enable) begin
      state_d = ST_BLANK;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == ST_BLANK) begin
      if (cnt_q == BLANK_LAST) begin
        state_d = ST_SHOW;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      if (cnt_q == SHOW_LAST) begin
        state_d      = ST_BLANK;
        cnt_d        = '0;
        idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        frame_done_d = (idx_q == IDX_LAST);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Segments hold through the first blank cycle and take the next digit's pattern on the
    // last one, so the segment bus never moves in a cycle where a select switches on or off.
    if (!bus.enable) begin
      seg_d = SEG_OFF;
      dp_d  = SEG_LOW;
    end else if (state_d == ST_SHOW) begin
      dig_sel_d = SEL_OFF ^ (DIGITS'(1) << idx_d);
      seg_d     = act_seg_d[idx_d] ^ SEG_OFF;
      dp_d      = act_dp_d[idx_d] ^ SEG_LOW;
    end else if (cnt_d == BLANK_LAST) begin
      seg_d = act_seg_d[idx_d] ^ SEG_OFF;
      dp_d  = act_dp_d[idx_d] ^ SEG_LOW;
    end else if (cnt_d != '0) begin
      seg_d = SEG_OFF;
      dp_d  = SEG_LOW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      act_seg_q    <= '0;
      act_dp_q     <= '0;
      pend_seg_q   <= '0;
      pend_dp_q    <= '0;
      pend_vld_q   <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= SEG_LOW;
      dig_sel_q    <= SEL_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      act_seg_q    <= act_seg_d;
      act_dp_q     <= act_dp_d;
      pend_seg_q   <= pend_seg_d;
      pend_dp_q    <= pend_dp_d;
      pend_vld_q   <= pend_vld_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_sel_q    <= dig_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.dig_sel    = dig_sel_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sm_7seg_scan_ctrl.sv
// Scoreboard bench for sm_7seg_scan_ctrl: a frame-position model queues expected pin values per
// cycle; a negedge checker pops and compares, plus per-cycle select/segment invariants.
module tb_sm_7seg_scan_ctrl;
  localparam int D     = 3;
  localparam int S     = 4;
  localparam int B     = 2;
  localparam int SLOT  = B + S;
  localparam int FRAME = D * SLOT;

  logic clk = 1'b0;
  logic rst;

  sm_7seg_scan_ctrl_if #(.DIGITS(D)) bus ();

  sm_7seg_scan_ctrl #(
    .DIGITS(D), .SHOW_CYCLES(S), .BLANK_CYCLES(B), .SEG_ACT_LOW(1), .SEL_ACT_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame position plus double buffer, stepped on each active edge.
  logic [6:0]  m_aseg [D];
  logic [6:0]  m_pseg [D];
  logic [D-1:0] m_adp, m_pdp;
  logic        m_pvld;
  int          m_pos;
  logic        m_fd;
  logic [6:0]  m_seg;
  logic        m_dp;
  logic [D-1:0] m_sel;
  logic [11:0] sb_q [$];

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_aseg[i] = 7'h00;
      m_pseg[i] = 7'h00;
    end
    m_adp  = '0;
    m_pdp  = '0;
    m_pvld = 1'b0;
    m_pos  = 0;
    m_fd   = 1'b0;
    m_seg  = 7'h7F;
    m_dp   = 1'b1;
    m_sel  = '1;
    sb_q.delete();
  endtask

  task automatic model_step();
    int slot;
    int off;
    if (m_fd && bus.enable) begin
      if (bus.load) begin
        for (int i = 0; i < D; i++) m_aseg[i] = bus.seg_in[7*i +: 7];
        m_adp = bus.dp_in;
      end else if (m_pvld) begin
        for (int i = 0; i < D; i++) m_aseg[i] = m_pseg[i];
        m_adp = m_pdp;
      end
      m_pvld = 1'b0;
    end else if (bus.load) begin
      for (int i = 0; i < D; i++) m_pseg[i] = bus.seg_in[7*i +: 7];
      m_pdp  = bus.dp_in;
      m_pvld = 1'b1;
    end

    if (!bus.enable) begin
      m_pos = 0;
      m_fd  = 1'b0;
      m_seg = 7'h7F;
      m_dp  = 1'b1;
      m_sel = '1;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
      m_fd  = (m_pos == 0);
      slot  = m_pos / SLOT;
      off   = m_pos % SLOT;
      m_sel = '1;
      if (off >= B) begin
        m_sel[slot] = 1'b0;
        m_seg = ~m_aseg[slot];
        m_dp  = ~m_adp[slot];
      end else if (off == B - 1) begin
        m_seg = ~m_aseg[slot];
        m_dp  = ~m_adp[slot];
      end else if (off != 0) begin
        m_seg = 7'h7F;
        m_dp  = 1'b1;
      end
    end
    sb_q.push_back({m_fd, m_sel, m_dp, m_seg});
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Checker: pops one expectation per cycle and watches the select/segment invariants.
  logic [6:0]  prev_seg = 7'h7F;
  logic [11:0] exp_v;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("sel_onehot0", 32'($onehot0(~bus.dig_sel)), 32'd1);
        if (bus.seg !== prev_seg) chk("seg_chg_sel_off", 32'(bus.dig_sel), 32'h7);
        if (sb_q.size() > 0) begin
          exp_v = sb_q.pop_front();
          chk("pins", 32'({bus.frame_done, bus.dig_sel, bus.dp, bus.seg}), 32'(exp_v));
        end
      end
      prev_seg = bus.seg;
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7*D-1:0] s, input logic [D-1:0] d);
    bus.seg_in = s;
    bus.dp_in  = d;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
  endtask

  task automatic wait_fd();
    int n = 0;
    while (bus.frame_done !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("wait_fd", 32'(bus.frame_done), 32'd1);
  endtask

  task automatic wait_sel(input logic [D-1:0] v);
    int n = 0;
    while (bus.dig_sel !== v && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("wait_sel", 32'(bus.dig_sel), 32'(v));
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.load   = 1'b0;
    bus.seg_in = '0;
    bus.dp_in  = '0;
    #12;
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_dp", 32'(bus.dp), 32'h1);
    chk("rst_sel", 32'(bus.dig_sel), 32'h7);
    chk("rst_fd", 32'(bus.frame_done), 32'h0);
    @(negedge clk);
    rst        = 1'b0;
    bus.enable = 1'b1;

    // Free-running scan with blank patterns; measure the frame period.
    wait_fd();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_done !== 1'b1 && n < 64);
    chk("frame_len", 32'(n), 32'(FRAME));
    run(FRAME);

    // Mid-frame load shows up only after the next boundary.
    run(5);
    do_load({7'h06, 7'h5B, 7'h4F}, 3'b010);
    run(2 * FRAME + 4);

    // Two loads in one frame: last wins.
    run(3);
    do_load({7'h77, 7'h7C, 7'h39}, 3'b001);
    run(4);
    do_load({7'h3F, 7'h06, 7'h5B}, 3'b100);
    run(2 * FRAME + 4);

    // Load coincident with frame_done bypasses pending.
    wait_fd();
    do_load({7'h6D, 7'h7D, 7'h07}, 3'b111);
    run(FRAME + 3);

    // Drop enable during digit 1 show, load while dark, restart.
    wait_sel(3'b101);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("dis_sel", 32'(bus.dig_sel), 32'h7);
    chk("dis_seg", 32'(bus.seg), 32'h7F);
    run(2);
    do_load({7'h7F, 7'h6F, 7'h71}, 3'b000);
    run(3);
    bus.enable = 1'b1;
    run(2 * FRAME + 8);

    // Async reset in the middle of digit 2's show.
    wait_sel(3'b011);
    #2 rst = 1'b1;
    #1;
    chk("arst_seg", 32'(bus.seg), 32'h7F);
    chk("arst_dp", 32'(bus.dp), 32'h1);
    chk("arst_sel", 32'(bus.dig_sel), 32'h7);
    chk("arst_fd", 32'(bus.frame_done), 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    run(2 * FRAME + 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
